// File: rtl/vend_pkg.sv
// Shared vending definitions.
// Holds the change codes used by the vending FSM and the change dispenser,
// plus the state encoding of the change dispenser.
package vend_pkg;

  // Change owed, expressed in nickels
  localparam logic [2:0] NICKEL      = 3'b001;
  localparam logic [2:0] DIME        = 3'b010;
  localparam logic [2:0] NICKEL_DIME = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    EJECT_N,
    EJECT_D,
    RELEASE,
    DONE,
    FAULT
  } disp_state_e;

endpackage

// File: rtl/change_dispenser_handshake_timer.sv
// Handshake watchdog timer.
// Counts enabled cycles since the last clear and flags expiry once the count
// reaches TIMEOUT. The count holds at TIMEOUT so expiry cannot wrap away.
// Ports:
//   i_clk      clock
//   i_rst      synchronous active-high reset
//   i_clear    synchronous clear of the count (wins over i_en)
//   i_en       count enable
//   o_expired  high while count == TIMEOUT
module handshake_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] r_count;

  assign o_expired = (r_count == W'(TIMEOUT));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_en && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out change owed (in nickels) through a coin hopper
// using a four-phase request/ack handshake, one coin at a time. Dimes are
// preferred, nickels are the fallback. A sticky fault is raised when change
// cannot be paid or the hopper does not answer in time.
// Ports:
//   clock, reset         clock and synchronous active-high reset
//   change[2:0]          change owed in nickels, nonzero = request (while ready)
//   refill               reload both inventories (IDLE only)
//   hopper_ack           hopper acknowledge
//   ready, busy          state decodes
//   eject_nickel/dime    registered eject requests
//   done                 one-cycle pulse when a request is fully paid
//   fault                sticky fault, cleared only by reset
//   nickel_cnt/dime_cnt  coins in stock
module change_dispenser
  import vend_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int NICKEL_INIT = 8,
  parameter int DIME_INIT   = 8,
  parameter int TIMEOUT     = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       change,
  input  logic             refill,
  input  logic             hopper_ack,
  output logic             ready,
  output logic             busy,
  output logic             eject_nickel,
  output logic             eject_dime,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] nickel_cnt,
  output logic [CNT_W-1:0] dime_cnt
);

  disp_state_e      r_state;
  disp_state_e      w_next;
  logic [2:0]       r_amt;
  logic [CNT_W-1:0] r_nickel_cnt;
  logic [CNT_W-1:0] r_dime_cnt;
  logic             r_eject_n;
  logic             r_eject_d;
  logic             r_done;
  logic             r_fault;
  logic             w_take_n;
  logic             w_take_d;
  logic             w_expired;
  logic             w_tmr_clr;
  logic             w_tmr_en;

  // The watchdog restarts on every state change, so each ack edge gets its
  // own full TIMEOUT window.
  assign w_tmr_clr = (w_next != r_state);
  assign w_tmr_en  = (r_state == EJECT_N) || (r_state == EJECT_D) ||
                     (r_state == RELEASE);

  handshake_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_clear   (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  always_comb begin
    w_next   = r_state;
    w_take_n = 1'b0;
    w_take_d = 1'b0;
    case (r_state)
      IDLE: begin
        if (!refill && (change != 3'd0)) w_next = SELECT;
      end
      SELECT: begin
        // The nonzero-count checks here are what keep the counters from
        // underflowing on the later decrement.
        if ((r_amt >= DIME) && (r_dime_cnt != '0))        w_next = EJECT_D;
        else if ((r_amt >= NICKEL) && (r_nickel_cnt != '0)) w_next = EJECT_N;
        else                                                w_next = FAULT;
      end
      EJECT_N: begin
        if (hopper_ack) begin
          w_take_n = 1'b1;
          w_next   = RELEASE;
        end else if (w_expired) begin
          w_next = FAULT;
        end
      end
      EJECT_D: begin
        if (hopper_ack) begin
          w_take_d = 1'b1;
          w_next   = RELEASE;
        end else if (w_expired) begin
          w_next = FAULT;
        end
      end
      RELEASE: begin
        if (!hopper_ack)    w_next = (r_amt == 3'd0) ? DONE : SELECT;
        else if (w_expired) w_next = FAULT;
      end
      DONE:    w_next = IDLE;
      FAULT:   w_next = FAULT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_amt        <= 3'd0;
      r_nickel_cnt <= CNT_W'(NICKEL_INIT);
      r_dime_cnt   <= CNT_W'(DIME_INIT);
      r_eject_n    <= 1'b0;
      r_eject_d    <= 1'b0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state   <= w_next;
      // Registered outputs are decoded from the next state so they line up
      // with the state they belong to.
      r_eject_n <= (w_next == EJECT_N);
      r_eject_d <= (w_next == EJECT_D);
      r_done    <= (w_next == DONE);
      r_fault   <= (w_next == FAULT);
      if (r_state == IDLE) begin
        if (refill) begin
          r_nickel_cnt <= CNT_W'(NICKEL_INIT);
          r_dime_cnt   <= CNT_W'(DIME_INIT);
        end else if (change != 3'd0) begin
          r_amt <= change;
        end
      end
      if (w_take_n) begin
        r_nickel_cnt <= r_nickel_cnt - 1'b1;
        r_amt        <= r_amt - 3'd1;
      end
      if (w_take_d) begin
        r_dime_cnt <= r_dime_cnt - 1'b1;
        r_amt      <= r_amt - 3'd2;
      end
    end
  end

  assign ready        = (r_state == IDLE) && !refill;
  assign busy         = (r_state != IDLE) && (r_state != FAULT);
  assign eject_nickel = r_eject_n;
  assign eject_dime   = r_eject_d;
  assign done         = r_done;
  assign fault        = r_fault;
  assign nickel_cnt   = r_nickel_cnt;
  assign dime_cnt     = r_dime_cnt;

endmodule
